// File: rtl/dual_diagonal_diff_if.sv
// dual_diagonal_diff_if
// Groups the stream handshake, frame and error signals of dual_diagonal_diff.
//   i_in_data/i_in_valid/i_in_last/o_in_ready         : accumulated-word input stream
//   o_out_data/o_out_valid/o_out_last/o_out_index/i_out_ready : recovered-word output stream
//   o_err_frame/o_err_sticky/i_err_clear              : frame-misalignment reporting
// The i_/o_ prefixes are from the block's point of view; the slave modport is
// the block itself and the master modport is the surrounding logic.
interface dual_diagonal_diff_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_WORDS = 1024
);
    localparam int IW = $clog2(NUM_WORDS);

    logic [WIDTH-1:0] i_in_data;
    logic             i_in_valid;
    logic             o_in_ready;
    logic             i_in_last;
    logic [WIDTH-1:0] o_out_data;
    logic             o_out_valid;
    logic             i_out_ready;
    logic             o_out_last;
    logic [IW-1:0]    o_out_index;
    logic             o_err_frame;
    logic             o_err_sticky;
    logic             i_err_clear;

    modport slave (
        input  i_in_data, i_in_valid, i_in_last, i_out_ready, i_err_clear,
        output o_in_ready, o_out_data, o_out_valid, o_out_last, o_out_index,
               o_err_frame, o_err_sticky
    );

    modport master (
        output i_in_data, i_in_valid, i_in_last, i_out_ready, i_err_clear,
        input  o_in_ready, o_out_data, o_out_valid, o_out_last, o_out_index,
               o_err_frame, o_err_sticky
    );
endinterface

// File: rtl/dual_diagonal_diff.sv
// dual_diagonal_diff
// Undoes the dual-diagonal accumulation: within each vector of NUM_WORDS words
// every output word is the XOR of the current and previous accumulated input
// word, with the previous word taken as 0 at the start of a vector.
// Ports:
//   i_clock : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : dual_diagonal_diff_if.slave carrying the input stream, the
//             output stream (with last flag and word index) and the
//             frame-error pulse/sticky flag with its clear input.
// Output is a main register plus one skid register so that o_in_ready can be
// registered and never depends combinationally on i_out_ready.
module dual_diagonal_diff #(
    parameter int WIDTH     = 8,
    parameter int NUM_WORDS = 1024
) (
    input logic                  i_clock,
    input logic                  i_reset,
    dual_diagonal_diff_if.slave  bus
);
    localparam int            IW       = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

    logic [IW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_last_q, main_last_d;
    logic [IW-1:0]    main_index_q, main_index_d;
    logic             main_valid_q, main_valid_d;

    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_last_q, skid_last_d;
    logic [IW-1:0]    skid_index_q, skid_index_d;
    logic             skid_full_q, skid_full_d;

    logic             in_ready_q, in_ready_d;
    logic             err_frame_q, err_frame_d;
    logic             err_sticky_q, err_sticky_d;

    logic             accept;
    logic             drain;
    logic             main_free;
    logic             at_end;
    logic [WIDTH-1:0] res_data;
    logic             res_last;

    assign accept    = bus.i_in_valid && in_ready_q;
    assign drain     = main_valid_q && bus.i_out_ready;
    assign main_free = !main_valid_q || drain;
    assign at_end    = (cnt_q == LAST_IDX);
    assign res_data  = bus.i_in_data ^ prev_q;
    // An early last from upstream also closes the vector so we resync to it.
    assign res_last  = at_end || bus.i_in_last;

    always_comb begin
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        main_index_d = main_index_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_index_d = skid_index_q;
        skid_full_d  = skid_full_q;
        err_frame_d  = 1'b0;
        err_sticky_d = err_sticky_q;

        if (accept) begin
            if (res_last) begin
                cnt_d  = '0;
                prev_d = '0;
            end else begin
                cnt_d  = cnt_q + IW'(1);
                prev_d = bus.i_in_data;
            end
            // Covers both early last and missing last.
            err_frame_d = (bus.i_in_last != at_end);
        end

        // A new error in the same cycle as a clear keeps the flag set.
        if (err_frame_d) begin
            err_sticky_d = 1'b1;
        end else if (bus.i_err_clear) begin
            err_sticky_d = 1'b0;
        end

        // The skid word is always older than any new word, so it is promoted
        // first. accept implies the skid is empty (o_in_ready = !skid_full).
        if (main_free) begin
            if (skid_full_q) begin
                main_data_d  = skid_data_q;
                main_last_d  = skid_last_q;
                main_index_d = skid_index_q;
                main_valid_d = 1'b1;
                skid_full_d  = 1'b0;
            end else if (accept) begin
                main_data_d  = res_data;
                main_last_d  = res_last;
                main_index_d = cnt_q;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_data_d  = res_data;
            skid_last_d  = res_last;
            skid_index_d = cnt_q;
            skid_full_d  = 1'b1;
        end

        in_ready_d = !skid_full_d;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q        <= '0;
            prev_q       <= '0;
            main_data_q  <= '0;
            main_last_q  <= 1'b0;
            main_index_q <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_index_q <= '0;
            skid_full_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            err_frame_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            main_index_q <= main_index_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            skid_index_q <= skid_index_d;
            skid_full_q  <= skid_full_d;
            in_ready_q   <= in_ready_d;
            err_frame_q  <= err_frame_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.o_in_ready   = in_ready_q;
    assign bus.o_out_data   = main_data_q;
    assign bus.o_out_valid  = main_valid_q;
    assign bus.o_out_last   = main_last_q;
    assign bus.o_out_index  = main_index_q;
    assign bus.o_err_frame  = err_frame_q;
    assign bus.o_err_sticky = err_sticky_q;

endmodule
